// File: rtl/sa3_pkg.sv
// Shared types, sizes and operand-slot mapping for the 3x3 systolic tile controller.
package sa3_pkg;

  localparam int unsigned N_W    = 9;
  localparam int unsigned N_A    = 16;
  localparam int unsigned N_C    = 4;
  localparam int unsigned N_LOAD = 25;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 5;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LAST,
    RUN,
    STORE,
    FIN
  } state_t;

  // Slots 0..8 are b11..b33, slots 9..24 are a11..a44; both row-major, LSB first.
  function automatic int unsigned b_off(input int unsigned slot);
    return BYTE_W * slot;
  endfunction

  function automatic int unsigned a_off(input int unsigned slot);
    return BYTE_W * (slot - N_W);
  endfunction

endpackage

// File: rtl/sa3_operand_bank.sv
// 25-byte operand store feeding the array's parallel filter (sa_b) and activation (sa_a) buses.
module sa3_operand_bank
  import sa3_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [CNT_W-1:0]      idx,
  input  logic [BYTE_W-1:0]     data,
  output logic [BYTE_W*N_A-1:0] sa_a,
  output logic [BYTE_W*N_W-1:0] sa_b
);

  logic [BYTE_W-1:0] slot [N_LOAD];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < N_LOAD; i++) slot[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_LOAD; i++) begin
        if (we && (idx == CNT_W'(i))) slot[i] <= data;
      end
    end
  end

  always_comb begin
    sa_b = '0;
    sa_a = '0;
    for (int unsigned i = 0; i < N_W; i++) sa_b[b_off(i) +: BYTE_W] = slot[i];
    for (int unsigned i = N_W; i < N_LOAD; i++) sa_a[a_off(i) +: BYTE_W] = slot[i];
  end

endmodule

// File: rtl/sa3_tile_controller.sv
// Fetches one filter and one activation tile, runs the 3x3 array, and writes the 2x2 results back.
module sa3_tile_controller
  import sa3_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     act_base,
  input  logic [ADDR_W-1:0]     wgt_base,
  input  logic [ADDR_W-1:0]     out_base,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_W-1:0]     mem_rd_addr,
  input  logic [BYTE_W-1:0]     mem_rd_data,
  output logic                  mem_wr_en,
  output logic [ADDR_W-1:0]     mem_wr_addr,
  output logic [BYTE_W-1:0]     mem_wr_data,
  output logic                  sa_active,
  output logic [BYTE_W*N_A-1:0] sa_a,
  output logic [BYTE_W*N_W-1:0] sa_b,
  input  logic                  sa_done,
  input  logic [BYTE_W*N_C-1:0] sa_c
);

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [ADDR_W-1:0] act_q, wgt_q, out_q;
  logic [ADDR_W-1:0] act_d, wgt_d, out_d;
  logic [ADDR_W-1:0] rd_addr_d, wr_addr_d;
  logic [BYTE_W-1:0] wr_data_d;
  logic [BYTE_W-1:0] res [N_C];
  logic              res_we;
  logic              rd_pend;
  logic [CNT_W-1:0]  rd_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  // Next state plus the next value of every registered output.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    act_d     = act_q;
    wgt_d     = wgt_q;
    out_d     = out_q;
    rd_addr_d = mem_rd_addr;
    wr_addr_d = mem_wr_addr;
    wr_data_d = mem_wr_data;
    res_we    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d   = LOAD;
          cnt_d     = '0;
          act_d     = act_base;
          wgt_d     = wgt_base;
          out_d     = out_base;
          rd_addr_d = wgt_base;
        end
      end
      LOAD: begin
        if (cnt == CNT_W'(N_LOAD - 1)) begin
          state_d = LAST;
        end else begin
          cnt_d = cnt + CNT_W'(1);
          if (cnt_d < CNT_W'(N_W)) rd_addr_d = wgt_q + ADDR_W'(cnt_d);
          else                     rd_addr_d = act_q + ADDR_W'(cnt_d - CNT_W'(N_W));
        end
      end
      LAST: state_d = RUN;
      RUN: begin
        if (sa_done) begin
          state_d   = STORE;
          cnt_d     = '0;
          res_we    = 1'b1;
          wr_addr_d = out_q;
          wr_data_d = sa_c[BYTE_W-1:0];
        end
      end
      STORE: begin
        if (cnt == CNT_W'(N_C - 1)) begin
          state_d = FIN;
        end else begin
          cnt_d     = cnt + CNT_W'(1);
          wr_addr_d = out_q + ADDR_W'(cnt_d);
          wr_data_d = res[cnt_d[1:0]];
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs follow the state being entered, so strobes line up with that state's cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      act_q       <= '0;
      wgt_q       <= '0;
      out_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      sa_active   <= 1'b0;
      rd_pend     <= 1'b0;
      rd_idx      <= '0;
      for (int unsigned i = 0; i < N_C; i++) res[i] <= '0;
    end else begin
      cnt         <= cnt_d;
      act_q       <= act_d;
      wgt_q       <= wgt_d;
      out_q       <= out_d;
      busy        <= (state_d != IDLE);
      done        <= (state_d == FIN);
      mem_rd_en   <= (state_d == LOAD);
      mem_rd_addr <= rd_addr_d;
      mem_wr_en   <= (state_d == STORE);
      mem_wr_addr <= wr_addr_d;
      mem_wr_data <= wr_data_d;
      sa_active   <= (state_d == RUN);
      rd_pend     <= mem_rd_en;
      rd_idx      <= cnt;
      if (res_we) begin
        for (int unsigned i = 0; i < N_C; i++) res[i] <= sa_c[BYTE_W*i +: BYTE_W];
      end
    end
  end

  sa3_operand_bank u_bank (
    .clk  (clk),
    .rst  (rst),
    .we   (rd_pend),
    .idx  (rd_idx),
    .data (mem_rd_data),
    .sa_a (sa_a),
    .sa_b (sa_b)
  );

endmodule

// File: tb/tb_sa3_tile_controller.sv
// Scoreboard bench for sa3_tile_controller with a memory model and a behavioural 3x3 array.
module tb_sa3_tile_controller;

  localparam int unsigned ADDR_W = 8;
  localparam logic [31:0] STUB_C = 32'h44332211;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        act_base = '0, wgt_base = '0, out_base = '0;
  logic              busy, done;
  logic              mem_rd_en, mem_wr_en;
  logic [7:0]        mem_rd_addr, mem_wr_addr, mem_wr_data;
  logic [7:0]        mem_rd_data = '0;
  logic              sa_active;
  logic [127:0]      sa_a;
  logic [71:0]       sa_b;
  logic              sa_done = 1'b0;
  logic [31:0]       sa_c = '0;

  logic [7:0] mem [256];
  int checks = 0, errors = 0;
  int cyc = 0, t0 = 0, rel;
  int rd_cnt = 0, wr_cnt = 0, done_total = 0;
  int first_rd_rel, last_rd_rel, first_wr_rel, last_wr_rel, first_act_rel, done_rel;
  int arr_lat = 17, act_cnt = 0;
  bit stub_en = 1'b0, noise_en = 1'b0;
  logic [7:0] exp_rd_q[$], exp_wa_q[$], exp_wd_q[$], exp_done_q[$];
  logic [127:0] exp_a;
  logic [71:0]  exp_b;

  sa3_tile_controller #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .act_base(act_base), .wgt_base(wgt_base), .out_base(out_base),
    .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .sa_active(sa_active), .sa_a(sa_a), .sa_b(sa_b), .sa_done(sa_done), .sa_c(sa_c)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // 2x2 valid convolution of a 4x4 tile with a 3x3 filter, results truncated to 8 bits.
  function automatic logic [31:0] conv(input logic [127:0] a, input logic [71:0] b);
    logic [31:0] r;
    int s;
    r = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        s = 0;
        for (int m = 0; m < 3; m++)
          for (int n = 0; n < 3; n++)
            s += int'(a[8*((i+m)*4 + j+n) +: 8]) * int'(b[8*(m*3+n) +: 8]);
        r[8*(i*2+j) +: 8] = 8'(s);
      end
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Memory: one-cycle read latency, writes land at the clock edge.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    if (mem_wr_en) mem[mem_wr_addr] = mem_wr_data;
  end

  // Array model: sa_done on the arr_lat-th cycle of sa_active; optional stray pulses when not running.
  always @(posedge clk) begin
    if (sa_active && !sa_done) begin
      act_cnt = act_cnt + 1;
      if (act_cnt == arr_lat - 1) begin
        sa_done <= 1'b1;
        sa_c    <= stub_en ? STUB_C : conv(sa_a, sa_b);
      end
    end else if (noise_en && (!busy || mem_wr_en) && $urandom_range(0, 5) == 0) begin
      sa_done <= 1'b1;
      sa_c    <= $urandom;
    end else begin
      sa_done <= 1'b0;
    end
    if (!sa_active) act_cnt = 0;
  end

  // Reference model: read order, operand image and write-back derived from memory contents.
  task automatic push_expect(input logic [7:0] a, input logic [7:0] w, input logic [7:0] o);
    logic [7:0] ad;
    logic [31:0] c;
    for (int i = 0; i < 9; i++) begin
      ad = w + 8'(i);
      exp_rd_q.push_back(ad);
      exp_b[8*i +: 8] = mem[ad];
    end
    for (int j = 0; j < 16; j++) begin
      ad = a + 8'(j);
      exp_rd_q.push_back(ad);
      exp_a[8*j +: 8] = mem[ad];
    end
    c = stub_en ? STUB_C : conv(exp_a, exp_b);
    for (int k = 0; k < 4; k++) begin
      exp_wa_q.push_back(o + 8'(k));
      exp_wd_q.push_back(c[8*k +: 8]);
    end
    exp_done_q.push_back(o + 8'd3);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a read, a write or done.
  always @(negedge clk) begin
    rel = cyc - t0 + 1;
    if (mem_rd_en) begin
      if (rd_cnt == 0) first_rd_rel = rel;
      last_rd_rel = rel;
      rd_cnt++;
      if (exp_rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_read: addr %0h with none pending", mem_rd_addr);
      end else chk("rd_addr", mem_rd_addr, exp_rd_q.pop_front());
    end
    if (mem_wr_en) begin
      if (wr_cnt == 0) first_wr_rel = rel;
      last_wr_rel = rel;
      wr_cnt++;
      if (exp_wa_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: addr %0h data %0h with none pending", mem_wr_addr, mem_wr_data);
      end else begin
        chk("wr_addr", mem_wr_addr, exp_wa_q.pop_front());
        chk("wr_data", mem_wr_data, exp_wd_q.pop_front());
      end
    end
    if (sa_active && first_act_rel < 0) first_act_rel = rel;
    if (done) begin
      done_total++;
      done_rel = rel;
      if (exp_done_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: done with no operation pending");
      end else chk("done_after_last_write", mem_wr_addr, exp_done_q.pop_front());
    end
  end

  task automatic run_op(input logic [7:0] a, input logic [7:0] w, input logic [7:0] o);
    @(negedge clk);
    act_base = a; wgt_base = w; out_base = o; start = 1'b1;
    push_expect(a, w, o);
    @(posedge clk);
    #1;
    t0 = cyc;
    rd_cnt = 0; wr_cnt = 0;
    first_act_rel = -1; first_rd_rel = -1; first_wr_rel = -1; done_rel = -1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [127:0] ea;
    int d0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

    // Reset values
    #12;
    chk("rst_busy", busy, 0);        chk("rst_done", done, 0);
    chk("rst_rd_en", mem_rd_en, 0);  chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_active", sa_active, 0); chk("rst_rd_addr", mem_rd_addr, 0);
    chk("rst_wr_addr", mem_wr_addr, 0); chk("rst_wr_data", mem_wr_data, 0);
    chk("rst_sa_a", sa_a, 0);        chk("rst_sa_b", sa_b, 0);
    @(negedge clk); rst = 1'b1;

    // Load order and write-back with the stub array
    for (int i = 0; i < 9; i++) mem[8'h10 + i] = 8'(i + 1);
    for (int j = 0; j < 16; j++) mem[8'h40 + j] = 8'h20 + 8'(j);
    stub_en = 1'b1;
    run_op(8'h40, 8'h10, 8'h80);
    wait_done(120);
    chk("rd_count", rd_cnt, 25);
    chk("first_rd_cycle", first_rd_rel, 1);
    chk("last_rd_cycle", last_rd_rel, 25);
    chk("run_start_cycle", first_act_rel, 27);
    chk("first_wr_cycle", first_wr_rel, 44);
    chk("last_wr_cycle", last_wr_rel, 47);
    chk("done_cycle", done_rel, 48);
    chk("idle_cycle49", busy, 0);
    chk("sa_b_load", sa_b, 72'h090807060504030201);
    for (int j = 0; j < 16; j++) ea[8*j +: 8] = 8'h20 + 8'(j);
    chk("sa_a_load", sa_a, ea);
    chk("wb_mem", {mem[8'h83], mem[8'h82], mem[8'h81], mem[8'h80]}, STUB_C);

    // Real array: unit filter over activations 1..16
    stub_en = 1'b0;
    for (int i = 0; i < 9; i++) mem[8'h10 + i] = 8'd1;
    for (int j = 0; j < 16; j++) mem[8'h40 + j] = 8'(j + 1);
    run_op(8'h40, 8'h10, 8'h90);
    wait_done(120);
    chk("c11", mem[8'h90], 54); chk("c12", mem[8'h91], 63);
    chk("c21", mem[8'h92], 90); chk("c22", mem[8'h93], 99);

    // Address wrap on the activation tile
    run_op(8'hF8, 8'h05, 8'h60);
    wait_done(120);
    chk("wrap_a11", sa_a[7:0], mem[8'hF8]);
    chk("wrap_a44", sa_a[127:120], mem[8'h07]);

    // Start pulses while busy are ignored
    d0 = done_total;
    run_op(8'h30, 8'h20, 8'hA0);
    repeat (10) @(negedge clk);
    act_base = 8'h00; wgt_base = 8'h00; out_base = 8'h00; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (20) @(negedge clk);
    act_base = 8'hC0; wgt_base = 8'hD0; out_base = 8'hE0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(120);
    repeat (60) @(negedge clk);
    chk("busy_single_done", done_total - d0, 1);
    chk("busy_no_restart", busy, 0);
    chk("busy_rd_count", rd_cnt, 25);

    // Reset during RUN
    run_op(8'h50, 8'h70, 8'hB0);
    repeat (35) @(negedge clk);
    chk("mid_in_run", sa_active, 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_active_async", sa_active, 0);
    chk("mid_busy", busy, 0);       chk("mid_rd_en", mem_rd_en, 0);
    chk("mid_wr_en", mem_wr_en, 0); chk("mid_rd_addr", mem_rd_addr, 0);
    chk("mid_sa_a", sa_a, 0);       chk("mid_sa_b", sa_b, 0);
    exp_rd_q.delete(); exp_wa_q.delete(); exp_wd_q.delete(); exp_done_q.delete();
    repeat (4) @(negedge clk);
    chk("mid_no_writes", wr_cnt, 0);
    rst = 1'b1;
    run_op(8'h50, 8'h70, 8'hB0);
    wait_done(120);
    chk("post_rst_sa_b", sa_b, exp_b);

    // Randomized operations with varying array latency and stray sa_done pulses
    noise_en = 1'b1;
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      arr_lat = $urandom_range(2, 30);
      run_op(8'($urandom), 8'($urandom), 8'($urandom));
      wait_done(120);
      chk("rand_sa_a", sa_a, exp_a);
      chk("rand_sa_b", sa_b, exp_b);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    noise_en = 1'b0;
    repeat (5) @(negedge clk);
    chk("left_reads", exp_rd_q.size(), 0);
    chk("left_writes", exp_wa_q.size(), 0);
    chk("left_done", exp_done_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
